cola_teclado: RTL and testbench

COLA_TECLADO -- requirements
Module: cola_teclado

---
 rtl/cola_teclado_pkg.sv | 18 +
 rtl/cola_teclado_if.sv | 16 +
 rtl/cola_teclado_onehot_a_indice.sv | 18 +
 rtl/cola_teclado.sv | 64 ++++++
 tb/tb_cola_teclado.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/cola_teclado_pkg.sv
// Shared keypad definitions: default geometry, key-code type and code mapping.
// Used by the debounce stage, the key FIFO and downstream consumers.
package cola_teclado_pkg;

   localparam int WIDTH_DEF = 4;
   localparam int DEPTH_DEF = 4;
   localparam int IDX_W     = $clog2(WIDTH_DEF);
   localparam int CODE_W    = 2 * IDX_W;

   typedef logic [CODE_W-1:0] key_code_t;

   // Code = row * WIDTH + col
   function automatic key_code_t calc_code(input logic [IDX_W-1:0] row_idx,
                                           input logic [IDX_W-1:0] col_idx);
      return key_code_t'(key_code_t'(row_idx) * key_code_t'(WIDTH_DEF) + key_code_t'(col_idx));
   endfunction

endpackage

// File: rtl/cola_teclado_if.sv
// Keypad press input and key-code output handshake of the key FIFO.
interface cola_teclado_if
   import cola_teclado_pkg::*;
#(parameter int WIDTH = WIDTH_DEF);
   logic             key_event;
   logic [WIDTH-1:0] key_col;
   logic [WIDTH-1:0] key_row;
   logic             key_valid;
   key_code_t        key_code;
   logic             key_ready;

   modport master (output key_event, key_col, key_row, key_ready,
                   input  key_valid, key_code);
   modport slave  (input  key_event, key_col, key_row, key_ready,
                   output key_valid, key_code);
endinterface

// File: rtl/cola_teclado_onehot_a_indice.sv
// One-hot vector to bit index, plus a flag that exactly one bit is set.
module onehot_a_indice #(
   parameter int WIDTH = 4,
   parameter int IW    = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] vec,
   output logic [IW-1:0]    idx,
   output logic             one
);
   // Zero bits or several bits both count as not one-hot
   assign one = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);

   always_comb begin
      idx = '0;
      for (int i = 0; i < WIDTH; i++)
         if (vec[i]) idx = IW'(i);
   end
endmodule

// File: rtl/cola_teclado.sv
// Keypad key FIFO: validates debounced presses, stores key codes first-word-fall-through,
// and keeps sticky overflow / bad-code flags.
module cola_teclado
   import cola_teclado_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   cola_teclado_if.slave          kb,
   input  logic                   clr_flags,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   err_code
);
   localparam int IW = $clog2(WIDTH);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [IW-1:0] row_idx, col_idx;
   logic          row_ok, col_ok;

   onehot_a_indice #(.WIDTH(WIDTH)) u_row (.vec(kb.key_row), .idx(row_idx), .one(row_ok));
   onehot_a_indice #(.WIDTH(WIDTH)) u_col (.vec(kb.key_col), .idx(col_idx), .one(col_ok));

   key_code_t     mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          good, bad, pop, push, drop_full;

   assign good      = kb.key_event & row_ok & col_ok;
   assign bad       = kb.key_event & ~(row_ok & col_ok);
   assign pop       = (count != '0) & kb.key_ready;
   // A pop in the same cycle frees a slot, so a full FIFO can still accept
   assign push      = good & ((count != FULL) | pop);
   assign drop_full = good & ~push;

   assign kb.key_valid = (count != '0);
   assign kb.key_code  = kb.key_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk)
      if (!rst && push) mem[wr_ptr] <= calc_code(row_idx, col_idx);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         err_code <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // A new drop in the clearing cycle keeps the flag set
         overflow <= (overflow & ~clr_flags) | drop_full;
         err_code <= (err_code & ~clr_flags) | bad;
      end
   end
endmodule

// File: tb/tb_cola_teclado.sv
// Directed and scoreboard-checked stimulus for the keypad key FIFO.
module tb_cola_teclado;
   import cola_teclado_pkg::*;

   localparam int W = 4;
   localparam int D = 4;

   logic clk = 0;
   logic rst;
   logic clr_flags;
   logic [2:0] count;
   logic overflow, err_code;
   int tests = 0;
   int failed = 0;

   cola_teclado_if #(.WIDTH(W)) kb ();

   cola_teclado #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .kb(kb), .clr_flags(clr_flags),
      .count(count), .overflow(overflow), .err_code(err_code)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] r, input logic [3:0] c);
      kb.key_event = 1'b1;
      kb.key_row   = r;
      kb.key_col   = c;
      tick();
      kb.key_event = 1'b0;
   endtask

   task automatic state(input string tag, input int cnt, input int vld, input int code,
                        input int ovf, input int err);
      chk({tag, ".count"},    32'(count),        32'(cnt));
      chk({tag, ".valid"},    32'(kb.key_valid), 32'(vld));
      chk({tag, ".code"},     32'(kb.key_code),  32'(code));
      chk({tag, ".overflow"}, 32'(overflow),     32'(ovf));
      chk({tag, ".err"},      32'(err_code),     32'(err));
   endtask

   function automatic int idx_of(input logic [3:0] v);
      int r = 0;
      for (int i = 0; i < 4; i++) if (v[i]) r = i;
      return r;
   endfunction

   initial begin
      int q[$];
      logic m_ovf, m_err;
      logic [3:0] r, c;
      logic ev, rdy, clr, ok, pp;

      rst = 1; clr_flags = 0;
      kb.key_event = 0; kb.key_row = 0; kb.key_col = 0; kb.key_ready = 0;
      tick(); tick();
      rst = 0;
      state("reset", 0, 0, 0, 0, 0);

      // Single press row 2 col 1 -> code 9, visible after one edge
      press(4'b0100, 4'b0010);
      state("first", 1, 1, 9, 0, 0);
      kb.key_ready = 1; tick(); kb.key_ready = 0;
      state("first_pop", 0, 0, 0, 0, 0);

      // Order of 0,5,10,15
      press(4'b0001, 4'b0001);
      press(4'b0010, 4'b0010);
      press(4'b0100, 4'b0100);
      press(4'b1000, 4'b1000);
      state("four", 4, 1, 0, 0, 0);
      kb.key_ready = 1;
      chk("drain0", 32'(kb.key_code), 0);  tick();
      chk("drain1", 32'(kb.key_code), 5);  tick();
      chk("drain2", 32'(kb.key_code), 10); tick();
      chk("drain3", 32'(kb.key_code), 15); tick();
      kb.key_ready = 0;
      state("drained", 0, 0, 0, 0, 0);

      // Full: codes 1,2,4,8, then code 3 dropped
      press(4'b0001, 4'b0010);
      press(4'b0001, 4'b0100);
      press(4'b0010, 4'b0001);
      press(4'b0100, 4'b0001);
      press(4'b0001, 4'b1000);
      state("ovf_drop", 4, 1, 1, 1, 0);
      // Full with pop: code 3 takes the freed slot
      kb.key_ready = 1; press(4'b0001, 4'b1000); kb.key_ready = 0;
      state("full_pushpop", 4, 1, 2, 1, 0);
      // Clear and new drop together: flag stays set
      clr_flags = 1; press(4'b0001, 4'b1000); clr_flags = 0;
      state("clr_vs_set", 4, 1, 2, 1, 0);
      clr_flags = 1; tick(); clr_flags = 0;
      chk("ovf_clr", 32'(overflow), 0);
      kb.key_ready = 1;
      chk("full0", 32'(kb.key_code), 2); tick();
      chk("full1", 32'(kb.key_code), 4); tick();
      chk("full2", 32'(kb.key_code), 8); tick();
      chk("full3", 32'(kb.key_code), 3); tick();
      kb.key_ready = 0;
      state("full_empty", 0, 0, 0, 0, 0);

      // Bad codes: multi-hot row with simultaneous pop, then empty row
      press(4'b0010, 4'b0100);
      kb.key_ready = 1; press(4'b0110, 4'b0001); kb.key_ready = 0;
      state("bad_multi", 0, 0, 0, 0, 1);
      press(4'b0010, 4'b0100);
      press(4'b0000, 4'b0001);
      state("bad_zero", 1, 1, 6, 0, 1);
      press(4'b0001, 4'b0011);
      chk("bad_col.count", 32'(count), 1);
      clr_flags = 1; tick(); clr_flags = 0;
      chk("err_clr", 32'(err_code), 0);

      // count=1 push+pop: new code becomes head
      kb.key_ready = 1; press(4'b0010, 4'b1000); kb.key_ready = 0;
      state("one_pushpop", 1, 1, 7, 0, 0);

      // Reset beats press/pop with flags set
      press(4'b1000, 4'b0001);
      press(4'b1111, 4'b0001);
      state("pre_rst", 2, 1, 7, 0, 1);
      rst = 1; kb.key_ready = 1; press(4'b0001, 4'b0001);
      rst = 0; kb.key_ready = 0;
      state("rst_prio", 0, 0, 0, 0, 0);
      press(4'b1000, 4'b0100);
      state("post_rst", 1, 1, 14, 0, 0);
      kb.key_ready = 1; tick(); kb.key_ready = 0;

      // Random traffic against a queue model
      q = {}; m_ovf = 0; m_err = 0;
      for (int n = 0; n < 1000; n++) begin
         ev  = ($urandom_range(0, 99) < 60);
         rdy = ($urandom_range(0, 99) < 45);
         clr = ($urandom_range(0, 99) < 5);
         r = ($urandom_range(0, 9) < 8) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         c = ($urandom_range(0, 9) < 8) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         ok = ev && ($countones(r) == 1) && ($countones(c) == 1);
         pp = rdy && (q.size() != 0);
         if (clr) begin m_ovf = 0; m_err = 0; end
         if (ev && !ok) m_err = 1;
         if (ok && q.size() == D && !pp) m_ovf = 1;
         if (pp) void'(q.pop_front());
         if (ok && !(m_ovf && q.size() == D)) begin
            if (q.size() < D) q.push_back(idx_of(r) * 4 + idx_of(c));
         end
         kb.key_event = ev; kb.key_row = r; kb.key_col = c;
         kb.key_ready = rdy; clr_flags = clr;
         tick();
         chk("rnd.count", 32'(count), 32'(q.size()));
         chk("rnd.valid", 32'(kb.key_valid), 32'(q.size() != 0));
         chk("rnd.code",  32'(kb.key_code), (q.size() != 0) ? 32'(q[0]) : 0);
         chk("rnd.ovf",   32'(overflow), 32'(m_ovf));
         chk("rnd.err",   32'(err_code), 32'(m_err));
      end
      kb.key_event = 0; kb.key_ready = 0; clr_flags = 0;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
